// File: rtl/vga_timing_pkg.sv
// Shared 640x480 @ 60 Hz raster timing constants.
// Holds the porch and sync widths, the derived line and frame totals, the
// sync-window bounds and the "outside the active region" sentinel codes.
// The colour/character stage imports the same constants, so both ends of the
// pixelCnt/lineCnt interface agree on the geometry.
package vga_timing_pkg;

  // Horizontal timing, in pixels.
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;

  // Vertical timing, in lines.
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;

  // Derived totals: 800 pixels per line, 525 lines per frame.
  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // Sync windows, inclusive bounds: hSync 656..751, vSync 490..491.
  localparam int VGA_H_SYNC_FIRST = VGA_H_ACTIVE + VGA_H_FRONT;
  localparam int VGA_H_SYNC_LAST  = VGA_H_SYNC_FIRST + VGA_H_SYNC - 1;
  localparam int VGA_V_SYNC_FIRST = VGA_V_ACTIVE + VGA_V_FRONT;
  localparam int VGA_V_SYNC_LAST  = VGA_V_SYNC_FIRST + VGA_V_SYNC - 1;

  // Internal axis counter width.
  localparam int VGA_CNT_W = 10;

  // Sentinels used outside the active region. Neither is ever a valid
  // coordinate, so a consumer can range-compare without checking activeVideo.
  localparam logic [9:0] PIXEL_NONE = 10'd1023;
  localparam logic [8:0] LINE_NONE  = 9'd511;

  // True when value lies in the inclusive window [first, last].
  function automatic logic in_window(input logic [VGA_CNT_W-1:0] value,
                                     input int first, input int last);
    return (int'(value) >= first) && (int'(value) <= last);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Mod-N position counter for one raster axis.
// Counts 0..N-1 while en is high and holds otherwise. Reset loads N-1, the
// last position, so the first enabled step after reset lands on 0.
// Ports:
//   clock       system clock
//   reset       synchronous, active-high; wins over en
//   en          advance by one position this cycle
//   count_next  value the counter loads on the coming edge (the parent
//               decodes this so its registered outputs align with position)
//   wrap        high when this enabled step goes from N-1 back to 0
module vga_axis_counter #(
  parameter int N = 800,
  parameter int W = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count_next,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count;

  assign wrap = en && (count == LAST);

  always_comb begin
    count_next = count;
    if (reset) begin
      count_next = LAST;
    end else if (wrap) begin
      count_next = '0;
    end else if (en) begin
      count_next = count + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values; blocking here would make ordering between blocks matter.
  always_ff @(posedge clock) begin
    count <= count_next;
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator for the VGA output path (640x480 @ 60 Hz default).
// Produces the pixel/line coordinates read by the colour stage, the sync pins
// and the active-video and frame-start flags. All outputs are registered.
// Ports:
//   clock        system clock; one pixel per cycle when pixelEn is high
//   reset        synchronous, active-high; loads position (H_TOTAL-1, V_TOTAL-1)
//   pixelEn      pixel-rate enable; low holds every counter and output
//   pixelCnt     active-region column 0..H_ACTIVE-1, else 1023
//   lineCnt      active-region row 0..V_ACTIVE-1, else 511
//   hSync        horizontal sync, asserted level SYNC_POL
//   vSync        vertical sync, asserted level SYNC_POL, whole lines
//   activeVideo  high when both pixelCnt and lineCnt are valid
//   frameStart   one-clock pulse on the step into position (0,0)
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FRONT  = VGA_H_FRONT,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BACK   = VGA_H_BACK,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FRONT  = VGA_V_FRONT,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BACK   = VGA_V_BACK,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pixelEn,
  output logic [9:0] pixelCnt,
  output logic [8:0] lineCnt,
  output logic       hSync,
  output logic       vSync,
  output logic       activeVideo,
  output logic       frameStart
);

  localparam int H_TOTAL    = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL    = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_FIRST   = H_ACTIVE + H_FRONT;
  localparam int HS_LAST    = HS_FIRST + H_SYNC - 1;
  localparam int VS_FIRST   = V_ACTIVE + V_FRONT;
  localparam int VS_LAST    = VS_FIRST + V_SYNC - 1;

  // Elaboration-time legality checks on the geometry.
  if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_width
    $error("vga_sync_gen: every timing width must be at least 1");
  end
  if (H_TOTAL > 1024) begin : g_bad_h_total
    $error("vga_sync_gen: H_TOTAL must not exceed 1024");
  end
  if (V_TOTAL > 1024) begin : g_bad_v_total
    $error("vga_sync_gen: V_TOTAL must not exceed 1024");
  end
  if (V_ACTIVE > 511) begin : g_bad_v_active
    $error("vga_sync_gen: V_ACTIVE must not exceed 511");
  end

  logic [VGA_CNT_W-1:0] h_next;
  logic [VGA_CNT_W-1:0] v_next;
  logic                 h_wrap;
  logic                 v_wrap;

  vga_axis_counter #(.N(H_TOTAL), .W(VGA_CNT_W)) u_h_counter (
    .clock      (clock),
    .reset      (reset),
    .en         (pixelEn),
    .count_next (h_next),
    .wrap       (h_wrap)
  );

  // The line counter steps once per horizontal wrap, so it wraps only when
  // the pixel counter wraps in the same cycle.
  vga_axis_counter #(.N(V_TOTAL), .W(VGA_CNT_W)) u_v_counter (
    .clock      (clock),
    .reset      (reset),
    .en         (h_wrap),
    .count_next (v_next),
    .wrap       (v_wrap)
  );

  // Decode the position about to be loaded, so the registered outputs line
  // up with the counters with zero skew.
  logic       h_active;
  logic       v_active;
  logic [9:0] pixel_d;
  logic [8:0] line_d;
  logic       hsync_d;
  logic       vsync_d;
  logic       frame_start_d;

  // NOTE: every signal written in an always_comb gets a value on all paths
  // (here by full assignment), otherwise synthesis infers a latch.
  always_comb begin
    h_active      = int'(h_next) < H_ACTIVE;
    v_active      = int'(v_next) < V_ACTIVE;
    pixel_d       = h_active ? h_next : PIXEL_NONE;
    line_d        = v_active ? v_next[8:0] : LINE_NONE;
    hsync_d       = in_window(h_next, HS_FIRST, HS_LAST) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = in_window(v_next, VS_FIRST, VS_LAST) ? SYNC_POL : ~SYNC_POL;
    // The counters may report a wrap while reset holds them at the last
    // position with pixelEn high; frameStart must stay low through reset.
    frame_start_d = v_wrap && !reset;
  end

  // No explicit reset branch: under reset the counters present the last
  // position, whose decode is exactly the reset value of every output, and
  // with pixelEn low the decode of the held position reproduces the outputs.
  always_ff @(posedge clock) begin
    pixelCnt    <= pixel_d;
    lineCnt     <= line_d;
    hSync       <= hsync_d;
    vSync       <= vsync_d;
    activeVideo <= h_active && v_active;
    frameStart  <= frame_start_d;
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen.
// dut_a is the standard 640x480 build (SYNC_POL=0); dut_b is a tiny-geometry
// build with SYNC_POL=1 so full frames, vertical sync and frame wrap fit in a
// short run. Both share clock, reset and pixelEn. The reference model tracks
// each raster as a single linear index into the frame and derives column,
// row, syncs and flags arithmetically from it.
module tb_vga_sync_gen;

  // Small geometry for dut_b: 15 pixels x 11 lines = 165 positions.
  localparam int B_HA = 8, B_HF = 2, B_HS = 3, B_HB = 2;
  localparam int B_VA = 6, B_VF = 2, B_VS = 2, B_VB = 1;
  localparam int A_FRAME = 800 * 525;
  localparam int B_FRAME = (B_HA + B_HF + B_HS + B_HB) * (B_VA + B_VF + B_VS + B_VB);

  logic       clock = 1'b0;
  logic       reset;
  logic       pixelEn;

  logic [9:0] pix_a, pix_b;
  logic [8:0] line_a, line_b;
  logic       hs_a, hs_b, vs_a, vs_b, act_a, act_b, fs_a, fs_b;

  always #5 clock = ~clock;

  vga_sync_gen dut_a (
    .clock       (clock),
    .reset       (reset),
    .pixelEn     (pixelEn),
    .pixelCnt    (pix_a),
    .lineCnt     (line_a),
    .hSync       (hs_a),
    .vSync       (vs_a),
    .activeVideo (act_a),
    .frameStart  (fs_a)
  );

  vga_sync_gen #(
    .H_ACTIVE (B_HA), .H_FRONT (B_HF), .H_SYNC (B_HS), .H_BACK (B_HB),
    .V_ACTIVE (B_VA), .V_FRONT (B_VF), .V_SYNC (B_VS), .V_BACK (B_VB),
    .SYNC_POL (1'b1)
  ) dut_b (
    .clock       (clock),
    .reset       (reset),
    .pixelEn     (pixelEn),
    .pixelCnt    (pix_b),
    .lineCnt     (line_b),
    .hSync       (hs_b),
    .vSync       (vs_b),
    .activeVideo (act_b),
    .frameStart  (fs_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input int expected);
    n_tests++;
    if (got !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expected);
    end
  endtask

  typedef struct {
    int pix;
    int line;
    int hs;
    int vs;
    int act;
    int fs;
  } exp_t;

  // Expected outputs for linear frame index p under the given geometry.
  function automatic exp_t predict(input int p, input bit fs,
                                   input int ha, input int hf, input int hsw, input int hb,
                                   input int va, input int vf, input int vsw, input bit pol);
    exp_t e;
    int   ht, h, v;
    ht    = ha + hf + hsw + hb;
    h     = p % ht;
    v     = p / ht;
    e.pix  = (h < ha) ? h : 1023;
    e.line = (v < va) ? v : 511;
    e.hs   = (h >= ha + hf && h < ha + hf + hsw) ? int'(pol) : int'(!pol);
    e.vs   = (v >= va + vf && v < va + vf + vsw) ? int'(pol) : int'(!pol);
    e.act  = (h < ha && v < va) ? 1 : 0;
    e.fs   = fs ? 1 : 0;
    return e;
  endfunction

  int p_a = 0, p_b = 0;
  bit mfs_a = 1'b0, mfs_b = 1'b0;

  task automatic compare_all();
    exp_t ea, eb;
    ea = predict(p_a, mfs_a, 640, 16, 96, 48, 480, 10, 2, 1'b0);
    eb = predict(p_b, mfs_b, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, 1'b1);
    check("a.pixelCnt",    pix_a,  ea.pix);
    check("a.lineCnt",     line_a, ea.line);
    check("a.hSync",       hs_a,   ea.hs);
    check("a.vSync",       vs_a,   ea.vs);
    check("a.activeVideo", act_a,  ea.act);
    check("a.frameStart",  fs_a,   ea.fs);
    check("b.pixelCnt",    pix_b,  eb.pix);
    check("b.lineCnt",     line_b, eb.line);
    check("b.hSync",       hs_b,   eb.hs);
    check("b.vSync",       vs_b,   eb.vs);
    check("b.activeVideo", act_b,  eb.act);
    check("b.frameStart",  fs_b,   eb.fs);
  endtask

  // One clock: apply inputs, advance the model on the edge, compare 1 ns later.
  task automatic step(input bit r, input bit e);
    reset   = r;
    pixelEn = e;
    @(posedge clock);
    if (r) begin
      p_a = A_FRAME - 1;  mfs_a = 1'b0;
      p_b = B_FRAME - 1;  mfs_b = 1'b0;
    end else if (e) begin
      p_a = (p_a + 1) % A_FRAME;  mfs_a = (p_a == 0);
      p_b = (p_b + 1) % B_FRAME;  mfs_b = (p_b == 0);
    end else begin
      mfs_a = 1'b0;
      mfs_b = 1'b0;
    end
    #1;
    compare_all();
  endtask

  initial begin
    int n;
    int vs_cycles;
    bit found;

    reset   = 1'b1;
    pixelEn = 1'b0;
    #2;

    // Reset, with pixelEn both low and high: position (last, last).
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("rst.pixelCnt",    pix_a,  1023);
    check("rst.lineCnt",     line_a, 511);
    check("rst.activeVideo", act_a,  0);
    check("rst.frameStart",  fs_a,   0);
    check("rst.hSync",       hs_a,   1);
    check("rst.vSync",       vs_a,   1);
    check("rst.b.hSync",     hs_b,   0);
    check("rst.b.vSync",     vs_b,   0);

    // First two enabled cycles after release.
    step(1'b0, 1'b1);
    check("rel1.pixelCnt",   pix_a, 0);
    check("rel1.lineCnt",    line_a, 0);
    check("rel1.active",     act_a, 1);
    check("rel1.frameStart", fs_a, 1);
    step(1'b0, 1'b1);
    check("rel2.frameStart", fs_a, 0);
    check("rel2.pixelCnt",   pix_a, 1);

    // Straight run: almost three standard lines, many small frames.
    for (int i = 0; i < 2300; i++) step(1'b0, 1'b1);

    // Enable stall 1,0,0,1 at pixelCnt=100.
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      step(1'b0, 1'b1);
      if (pix_a == 10'd100) found = 1'b1;
    end
    check("stall.reach100", found, 1);
    step(1'b0, 1'b0);
    check("stall.hold1", pix_a, 100);
    step(1'b0, 1'b0);
    check("stall.hold2", pix_a, 100);
    step(1'b0, 1'b1);
    check("stall.resume", pix_a, 101);

    // Small-frame period and vSync width, counted in enabled cycles.
    found = 1'b0;
    for (int i = 0; i < 4 * B_FRAME && !found; i++) begin
      step(1'b0, 1'b1);
      if (fs_b) found = 1'b1;
    end
    check("b.find_frame", found, 1);
    n = 0;
    vs_cycles = 0;
    do begin
      step(1'b0, 1'b1);
      n++;
      if (vs_b) vs_cycles++;
    end while (!fs_b && n < 4 * B_FRAME);
    check("b.frame_period", n, B_FRAME);
    check("b.vsync_cycles", vs_cycles, B_VS * (B_HA + B_HF + B_HS + B_HB));

    // Reset while dut_b is inside its vertical sync.
    found = 1'b0;
    for (int i = 0; i < 4 * B_FRAME && !found; i++) begin
      step(1'b0, 1'b1);
      if (vs_b) found = 1'b1;
    end
    check("b.find_vsync", found, 1);
    step(1'b1, 1'b1);
    check("vsrst.vSync",    vs_b,   0);
    check("vsrst.hSync",    hs_b,   0);
    check("vsrst.pixelCnt", pix_b,  1023);
    check("vsrst.lineCnt",  line_b, 511);
    step(1'b0, 1'b1);
    check("vsrst.restart_fs",  fs_b,  1);
    check("vsrst.restart_pix", pix_b, 0);

    // Random enable pattern with occasional resets.
    for (int i = 0; i < 8000; i++) begin
      step(($urandom_range(0, 249) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
